// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch responder: NOP encoding,
// cache geometry, miss-FSM state encoding, fetch-address layout and a
// saturating-increment helper used by the hit/miss counters.
package fetch_pkg;

  // Instruction driven whenever nothing valid is being returned. Opcode 00001,
  // deliberately not 16'h0000 which decodes as HALT.
  localparam logic [15:0] NOP_INSTR = 16'h0800;

  localparam int LINES  = 16;
  localparam int IDX_W  = 4;
  localparam int TAG_W  = 11;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_FILL = 2'd3
  } fetch_state_e;

  // Byte address as seen by the cache: tag | index | halfword offset.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic             off;
  } fetch_addr_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage for the direct-mapped instruction cache.
// Ports: i_clk/i_rst (async clear of valid bits), i_inv (sync clear of all
// valid bits), i_we/i_wr_* (sync line write), i_rd_idx -> o_rd_* (comb read).
module icache_array
  import fetch_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_inv,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [TAG_W-1:0]  i_wr_tag,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic              o_rd_valid,
  output logic [TAG_W-1:0]  o_rd_tag,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [DATA_W-1:0] r_data [LINES];
  logic [LINES-1:0]  w_valid_nxt;

  // Invalidate wipes everything, but a fill landing on the same edge still
  // marks its own line valid, so the write is applied after the clear.
  always_comb begin
    w_valid_nxt = r_valid;
    if (i_inv) begin
      w_valid_nxt = '0;
    end
    if (i_we) begin
      w_valid_nxt[i_wr_idx] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= '0;
    end else begin
      r_valid <= w_valid_nxt;
    end
  end

  // Tag and data contents are meaningless until their valid bit is set,
  // so they carry no reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/instr_fetch_resp.sv
// Instruction-fetch responder: 16-line direct-mapped cache with a miss FSM
// (IDLE/REQ/WAIT/FILL) that reads a fixed-handshake backing memory.
// Ports: i_fetch_en/i_instr_addr/i_inv from the PC unit; o_instr/o_stall/o_err
// back to it; o_mem_rd/o_mem_addr/i_mem_data/i_mem_valid to instruction
// memory; o_hit_cnt/o_miss_cnt saturating statistics.
module instr_fetch_resp
  import fetch_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_fetch_en,
  input  logic [15:0] i_instr_addr,
  input  logic        i_inv,
  output logic [15:0] o_instr,
  output logic        o_stall,
  output logic        o_err,
  output logic        o_mem_rd,
  output logic [15:0] o_mem_addr,
  input  logic [15:0] i_mem_data,
  input  logic        i_mem_valid,
  output logic [15:0] o_hit_cnt,
  output logic [15:0] o_miss_cnt
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;

  logic [15:0] r_miss_addr;
  logic [15:0] r_fill_data;
  logic [15:0] r_hit_cnt;
  logic [15:0] r_miss_cnt;

  fetch_addr_t       w_addr;
  fetch_addr_t       w_miss_addr;
  logic              w_rd_valid;
  logic [TAG_W-1:0]  w_rd_tag;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_req;
  logic              w_misalign;
  logic              w_hit;
  logic              w_miss;
  logic              w_fill_we;
  logic              w_capture;

  assign w_addr      = fetch_addr_t'(i_instr_addr);
  assign w_miss_addr = fetch_addr_t'(r_miss_addr);

  icache_array u_array (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_inv      (i_inv),
    .i_we       (w_fill_we),
    .i_wr_idx   (w_miss_addr.idx),
    .i_wr_tag   (w_miss_addr.tag),
    .i_wr_data  (r_fill_data),
    .i_rd_idx   (w_addr.idx),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_data)
  );

  // Lookup only means anything in IDLE; elsewhere the requester is holding
  // its address stable and we ignore it.
  assign w_req      = (r_state == ST_IDLE) && i_fetch_en && !i_rst;
  assign w_misalign = w_req && w_addr.off;
  assign w_hit      = w_req && !w_addr.off && w_rd_valid && (w_rd_tag == w_addr.tag);
  assign w_miss     = w_req && !w_addr.off && !(w_rd_valid && (w_rd_tag == w_addr.tag));
  assign w_capture  = (r_state == ST_WAIT) && i_mem_valid;

  always_comb begin
    w_state_nxt = r_state;
    o_instr     = NOP_INSTR;
    o_stall     = 1'b0;
    o_err       = 1'b0;
    o_mem_rd    = 1'b0;
    w_fill_we   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_misalign) begin
          o_err = 1'b1;
        end else if (w_hit) begin
          o_instr = w_rd_data;
        end else if (w_miss) begin
          o_stall     = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        o_stall     = 1'b1;
        o_mem_rd    = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        o_stall = 1'b1;
        if (i_mem_valid) begin
          w_state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        // Returned the same cycle the line is written, so the PC unit
        // advances without an extra lookup cycle.
        o_instr     = r_fill_data;
        w_fill_we   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Reset is asynchronous, so outputs must go quiet while it is held even
    // though the state register already reads IDLE.
    if (i_rst) begin
      w_state_nxt = ST_IDLE;
      o_instr     = NOP_INSTR;
      o_stall     = 1'b0;
      o_err       = 1'b0;
      o_mem_rd    = 1'b0;
      w_fill_we   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_miss_addr <= 16'h0000;
      r_fill_data <= 16'h0000;
    end else begin
      if (w_miss) begin
        r_miss_addr <= i_instr_addr;
      end
      if (w_capture) begin
        r_fill_data <= i_mem_data;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hit_cnt  <= 16'h0000;
      r_miss_cnt <= 16'h0000;
    end else begin
      if (w_hit) begin
        r_hit_cnt <= sat_inc(r_hit_cnt);
      end
      if (w_miss) begin
        r_miss_cnt <= sat_inc(r_miss_cnt);
      end
    end
  end

  // Miss address is reset to zero, so this also satisfies the idle value.
  assign o_mem_addr = r_miss_addr;
  assign o_hit_cnt  = r_hit_cnt;
  assign o_miss_cnt = r_miss_cnt;

endmodule

// File: tb/tb_instr_fetch_resp.sv
module tb_instr_fetch_resp;

  localparam int K_HIT  = 0;
  localparam int K_MISS = 1;
  localparam int K_ERR  = 2;
  localparam logic [15:0] NOP = 16'h0800;

  logic        clk;
  logic        i_rst;
  logic        i_fetch_en;
  logic [15:0] i_instr_addr;
  logic        i_inv;
  logic [15:0] o_instr;
  logic        o_stall;
  logic        o_err;
  logic        o_mem_rd;
  logic [15:0] o_mem_addr;
  logic [15:0] i_mem_data;
  logic        i_mem_valid;
  logic [15:0] o_hit_cnt;
  logic [15:0] o_miss_cnt;

  instr_fetch_resp dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_fetch_en   (i_fetch_en),
    .i_instr_addr (i_instr_addr),
    .i_inv        (i_inv),
    .o_instr      (o_instr),
    .o_stall      (o_stall),
    .o_err        (o_err),
    .o_mem_rd     (o_mem_rd),
    .o_mem_addr   (o_mem_addr),
    .i_mem_data   (i_mem_data),
    .i_mem_valid  (i_mem_valid),
    .o_hit_cnt    (o_hit_cnt),
    .o_miss_cnt   (o_miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Backing memory image and its responder.
  logic [15:0] mem_img [0:32767];
  int          mem_lat = 2;
  int          resp_lat;
  logic [15:0] resp_addr;
  int          rd_cnt = 0;
  logic [15:0] last_rd_addr = 16'h0;

  // Reference model: which word address each line holds, plus statistics.
  bit   [15:0] mvalid;
  logic [10:0] mtag  [16];
  logic [15:0] mdata [16];
  logic [15:0] exp_hits;
  logic [15:0] exp_miss;

  typedef struct {
    logic [15:0] addr;
    int          kind;
    int          lat;
    bit          inv_first;
    bit          inv_fill;
    logic [15:0] ei;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mvalid   = '0;
    exp_hits = 16'h0;
    exp_miss = 16'h0;
  endtask

  always @(negedge clk) begin
    if (o_mem_rd === 1'b1) begin
      rd_cnt++;
      last_rd_addr = o_mem_addr;
    end
  end

  initial begin
    i_mem_valid = 1'b0;
    i_mem_data  = 16'h0;
    forever begin
      @(negedge clk);
      if (o_mem_rd === 1'b1) begin
        resp_addr = o_mem_addr;
        resp_lat  = mem_lat;
        repeat (resp_lat) @(posedge clk);
        #1;
        i_mem_valid = 1'b1;
        i_mem_data  = mem_img[resp_addr[15:1]];
        @(posedge clk);
        #1;
        i_mem_valid = 1'b0;
        i_mem_data  = 16'($urandom);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // One fetch transaction, entered and left at posedge+1.
  task automatic fetch(input logic [15:0] a, input int kind, input logic [15:0] ei,
                       input int lat, input bit inv_first, input bit inv_fill, input string nm);
    int         rd0;
    int         stalls;
    logic [3:0] idx;
    idx     = a[4:1];
    mem_lat = lat;
    rd0     = rd_cnt;
    i_fetch_en   = 1'b1;
    i_instr_addr = a;
    i_inv        = inv_first;
    @(negedge clk);
    if (kind == K_ERR) begin
      chk({nm, ".err"}, o_err, 1);
      chk({nm, ".stall"}, o_stall, 0);
      chk({nm, ".instr"}, o_instr, NOP);
    end else if (kind == K_HIT) begin
      chk({nm, ".stall"}, o_stall, 0);
      chk({nm, ".err"}, o_err, 0);
      chk({nm, ".instr"}, o_instr, ei);
      if (exp_hits != 16'hFFFF) exp_hits++;
    end else begin
      chk({nm, ".miss_stall"}, o_stall, 1);
      chk({nm, ".miss_instr"}, o_instr, NOP);
      if (exp_miss != 16'hFFFF) exp_miss++;
      stalls = 1;
      @(posedge clk);
      #1;
      i_inv = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (o_stall !== 1'b1) break;
        stalls++;
      end
      chk({nm, ".stall_cycles"}, stalls, 2 + lat);
      chk({nm, ".fill_instr"}, o_instr, ei);
      chk({nm, ".fill_err"}, o_err, 0);
      if (inv_fill) i_inv = 1'b1;
    end
    // Model: invalidate takes effect on the edge it is sampled; a fill
    // completes even when invalidated on the same edge.
    if (inv_first) mvalid = '0;
    if (kind == K_MISS) begin
      if (inv_fill) mvalid = '0;
      mvalid[idx] = 1'b1;
      mtag[idx]   = a[15:5];
      mdata[idx]  = ei;
    end
    @(posedge clk);
    #1;
    i_inv      = 1'b0;
    i_fetch_en = 1'b0;
    @(negedge clk);
    chk({nm, ".hit_cnt"}, o_hit_cnt, exp_hits);
    chk({nm, ".miss_cnt"}, o_miss_cnt, exp_miss);
    chk({nm, ".rd_pulses"}, rd_cnt - rd0, (kind == K_MISS) ? 1 : 0);
    if (kind == K_MISS) chk({nm, ".mem_addr"}, last_rd_addr, a);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          rd0;
    logic [15:0] a;
    int          kind;
    logic [15:0] ei;
    logic [3:0]  idx;

    for (int i = 0; i < 32768; i++) mem_img[i] = 16'($urandom);
    mem_img[16'h0000] = 16'hC0DE;  // 0x0000
    mem_img[16'h0008] = 16'h5A5A;  // 0x0010
    mem_img[16'h0010] = 16'hBEEF;  // 0x0020
    mem_img[16'h0018] = 16'h1234;  // 0x0030
    mem_img[16'h0020] = 16'h7777;  // 0x0040

    tbl[0]  = '{16'h0000, K_MISS, 2, 1'b0, 1'b0, 16'hC0DE};
    tbl[1]  = '{16'h0010, K_MISS, 2, 1'b0, 1'b0, 16'h5A5A};
    tbl[2]  = '{16'h0010, K_HIT,  1, 1'b0, 1'b0, 16'h5A5A};
    tbl[3]  = '{16'h0030, K_MISS, 1, 1'b0, 1'b0, 16'h1234};
    tbl[4]  = '{16'h0010, K_MISS, 3, 1'b0, 1'b0, 16'h5A5A};
    tbl[5]  = '{16'h0011, K_ERR,  1, 1'b0, 1'b0, 16'h0800};
    tbl[6]  = '{16'h0020, K_MISS, 2, 1'b0, 1'b1, 16'hBEEF};
    tbl[7]  = '{16'h0020, K_HIT,  1, 1'b0, 1'b0, 16'hBEEF};
    tbl[8]  = '{16'h0010, K_MISS, 1, 1'b0, 1'b0, 16'h5A5A};
    tbl[9]  = '{16'h0000, K_MISS, 1, 1'b0, 1'b0, 16'hC0DE};
    tbl[10] = '{16'h0010, K_HIT,  1, 1'b1, 1'b0, 16'h5A5A};
    tbl[11] = '{16'h0010, K_MISS, 2, 1'b0, 1'b0, 16'h5A5A};
    tbl[12] = '{16'h0000, K_MISS, 1, 1'b0, 1'b0, 16'hC0DE};

    // Reset held with a fetch pending.
    i_rst        = 1'b1;
    i_fetch_en   = 1'b1;
    i_instr_addr = 16'h0000;
    i_inv        = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst.instr", o_instr, NOP);
    chk("rst.stall", o_stall, 0);
    chk("rst.err", o_err, 0);
    chk("rst.mem_rd", o_mem_rd, 0);
    chk("rst.mem_addr", o_mem_addr, 16'h0);
    chk("rst.hit_cnt", o_hit_cnt, 16'h0);
    chk("rst.miss_cnt", o_miss_cnt, 16'h0);
    @(posedge clk);
    #1;
    i_rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      fetch(tbl[i].addr, tbl[i].kind, tbl[i].ei, tbl[i].lat,
            tbl[i].inv_first, tbl[i].inv_fill, $sformatf("vec%0d", i));
    end
    chk("tbl.hit_total", o_hit_cnt, 16'd3);
    chk("tbl.miss_total", o_miss_cnt, 16'd9);

    // Reset asserted while the miss FSM waits on memory.
    mem_lat      = 4;
    rd0          = rd_cnt;
    i_fetch_en   = 1'b1;
    i_instr_addr = 16'h0040;
    @(negedge clk);
    chk("rstwait.miss", o_stall, 1);
    @(negedge clk);
    chk("rstwait.req", o_mem_rd, 1);
    @(posedge clk);
    #2;
    i_rst = 1'b1;
    #1;
    chk("rstwait.async_stall", o_stall, 0);
    chk("rstwait.async_instr", o_instr, NOP);
    i_fetch_en = 1'b0;
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rstwait.idle_stall", o_stall, 0);
      chk("rstwait.idle_rd", o_mem_rd, 0);
    end
    chk("rstwait.rd_pulses", rd_cnt - rd0, 1);
    chk("rstwait.hit_cnt", o_hit_cnt, 16'h0);
    chk("rstwait.miss_cnt", o_miss_cnt, 16'h0);
    @(posedge clk);
    #1;
    fetch(16'h0040, K_MISS, 16'h7777, 1, 1'b0, 1'b0, "rstwait.refetch");

    // Randomized traffic against the model, with stray invalidates and
    // spurious mem_valid pulses while idle.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        i_fetch_en  = 1'b0;
        i_inv       = ($urandom_range(0, 1) == 1);
        i_mem_valid = 1'b1;
        i_mem_data  = 16'($urandom);
        @(negedge clk);
        chk("rnd.idle_stall", o_stall, 0);
        chk("rnd.idle_instr", o_instr, NOP);
        if (i_inv) mvalid = '0;
        @(posedge clk);
        #1;
        i_inv       = 1'b0;
        i_mem_valid = 1'b0;
      end
      a = {11'($urandom_range(0, 3)), 4'($urandom), 1'b0};
      if ($urandom_range(0, 9) == 0) a[0] = 1'b1;
      idx = a[4:1];
      if (a[0]) begin
        kind = K_ERR;
        ei   = NOP;
      end else if (mvalid[idx] && mtag[idx] == a[15:5]) begin
        kind = K_HIT;
        ei   = mdata[idx];
      end else begin
        kind = K_MISS;
        ei   = mem_img[a[15:1]];
      end
      fetch(a, kind, ei, $urandom_range(1, 4),
            ($urandom_range(0, 11) == 0), ($urandom_range(0, 11) == 0),
            $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
